// File: rtl/toggle_sched_pkg.sv
// ============================================================================
// Module   : toggle_sched_pkg
// Purpose  : Shared state encoding, burst-count width and burst-length helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package toggle_sched_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // A programmed length of zero still runs a single toggle.
  function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(1) : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching from ptr+1 with wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/toggle_scheduler.sv
// ============================================================================
// Module   : toggle_scheduler
// Purpose  : Round-robin scheduler driving bursts of toggles on a shared T bank.
//            Define TOGGLE_COUNT_EN to add the 16-bit applied-toggle counter evt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module toggle_scheduler
  import toggle_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [NREQ*CNT_W-1:0] cnt,
  input  logic                  hold,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar
`ifdef TOGGLE_COUNT_EN
  ,
  output logic [15:0]           evt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   mask_q, mask_d;

  logic [NREQ-1:0]    w_win;
  logic [PW-1:0]      w_win_idx;
  logic [WIDTH-1:0]   w_win_mask;
  logic [CNT_W-1:0]   w_win_cnt;

  rr_arbiter #(
    .NREQ   (NREQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (w_win)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_mask = '0;
    w_win_cnt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = PW'(i);
        w_win_mask = mask[i*WIDTH +: WIDTH];
        w_win_cnt  = cnt[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    q_d     = q_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = w_win;
          mask_d  = w_win_mask;
          rem_d   = burst_len(w_win_cnt);
          ptr_d   = w_win_idx;
        end
      end
      BUSY: begin
        if (!hold) begin
          q_d   = q_q ^ mask_q;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over a toggle on the same edge.
    if (clr) q_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      mask_q  <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
    end
  end

`ifdef TOGGLE_COUNT_EN
  logic [15:0] evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else if ((state_q == BUSY) && !hold) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign evt = evt_q;
`endif

  assign gnt  = gnt_q;
  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

`default_nettype wire
